// File: rtl/multi_rate_timer.sv
// -----------------------------------------------------------------------------
// multi_rate_timer
//   Parametrised countdown timer with pause, auto-reload, a running flag and a
//   one-cycle expiry pulse. A single prescaler counts 0..CLK_HZ-1 and drives
//   both the 2 Hz and 1 Hz enables, so both are exactly periodic.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz (even, >= 4)
//   COUNT_W  width of the countdown value / counter
//   PRESC_W  prescaler width, derived from CLK_HZ
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-high reset
//   value          load value, sampled on start_timer and on auto-reload
//   start_timer    one-cycle load/restart request (highest priority)
//   pause          level; freezes prescaler and counter while in RUN
//   auto_reload    level; at expiry reload value and keep running
//   expired        high in EXPIRED state
//   expired_pulse  one-cycle pulse when the counter reaches 0
//   one_hz_enable  one-cycle pulse every CLK_HZ active clocks
//   two_hz_enable  one-cycle pulse every CLK_HZ/2 active clocks
//   counter        remaining seconds
//   running        high in RUN state (including while paused)
// -----------------------------------------------------------------------------
module multi_rate_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int COUNT_W = 4,
  parameter int PRESC_W = $clog2(CLK_HZ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COUNT_W-1:0] value,
  input  logic               start_timer,
  input  logic               pause,
  input  logic               auto_reload,
  output logic               expired,
  output logic               expired_pulse,
  output logic               one_hz_enable,
  output logic               two_hz_enable,
  output logic [COUNT_W-1:0] counter,
  output logic               running
);

  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2 - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] prescaler;

  logic at_half;
  logic at_last;

  assign at_half = (prescaler == PRESC_HALF);
  assign at_last = (prescaler == PRESC_LAST);

  // Timer FSM, prescaler, counter and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= PRESC_ZERO;
      counter       <= COUNT_ZERO;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
      one_hz_enable <= 1'b0;
      two_hz_enable <= 1'b0;
      running       <= 1'b0;
    end else if (start_timer) begin
      // Load/restart wins over pause and every state.
      counter       <= value;
      prescaler     <= PRESC_ZERO;
      one_hz_enable <= 1'b0;
      two_hz_enable <= 1'b0;
      if (value == COUNT_ZERO) begin
        state         <= EXPIRED;
        expired       <= 1'b1;
        running       <= 1'b0;
        expired_pulse <= 1'b1;
      end else begin
        state         <= RUN;
        expired       <= 1'b0;
        running       <= 1'b1;
        expired_pulse <= 1'b0;
      end
    end else begin
      one_hz_enable <= 1'b0;
      two_hz_enable <= 1'b0;
      expired_pulse <= 1'b0;
      case (state)
        IDLE: begin
          counter   <= COUNT_ZERO;
          prescaler <= PRESC_ZERO;
          expired   <= 1'b0;
          running   <= 1'b0;
        end
        RUN: begin
          if (!pause) begin
            prescaler     <= at_last ? PRESC_ZERO : prescaler + PRESC_ONE;
            two_hz_enable <= at_half || at_last;
            one_hz_enable <= at_last;
          end
          // In RUN the counter is only 0 on the cycle after an auto-reload
          // expiry, so a zero count here means "reload now".
          if (counter == COUNT_ZERO) begin
            counter <= value;
            if (value == COUNT_ZERO) begin
              state     <= EXPIRED;
              expired   <= 1'b1;
              running   <= 1'b0;
              prescaler <= PRESC_ZERO;
            end
          end else if (!pause && at_last) begin
            counter <= counter - COUNT_ONE;
            if (counter == COUNT_ONE) begin
              expired_pulse <= 1'b1;
              if (!auto_reload) begin
                // Prescaler has just wrapped to 0 and stays there.
                state   <= EXPIRED;
                expired <= 1'b1;
                running <= 1'b0;
              end
            end
          end
        end
        EXPIRED: begin
          prescaler <= PRESC_ZERO;
          expired   <= 1'b1;
          running   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          prescaler <= PRESC_ZERO;
          counter   <= COUNT_ZERO;
          expired   <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule
